// File: rtl/adaptimer_pkg.sv
// rtl/adaptimer_pkg.sv - shared opcodes, request encodings and FSM states for the adaptive timer
package adaptimer_pkg;

    localparam logic [2:0] CMD_NONE    = 3'd0;
    localparam logic [2:0] CMD_COARSER = 3'd1;
    localparam logic [2:0] CMD_FINER   = 3'd2;
    localparam logic [2:0] CMD_LOCK    = 3'd3;
    localparam logic [2:0] CMD_FLUSH   = 3'd4;

    localparam logic [7:0] RES_RESET_DEFAULT = 8'h10;

    typedef enum logic [1:0] {
        OP_SET_RES = 2'd0,
        OP_LOCK    = 2'd1,
        OP_FLUSH   = 2'd2,
        OP_RSVD    = 2'd3
    } req_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    function automatic logic res_in_range(input logic [7:0] res, input logic [7:0] lo,
                                          input logic [7:0] hi);
        return (res >= lo) && (res <= hi);
    endfunction

endpackage

// File: rtl/adaptimer_rr_arb.sv
// rtl/adaptimer_rr_arb.sv - two-port round-robin arbiter with last-grant register
module adaptimer_rr_arb (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    // last_grant = 1 means port 1 was served last, so port 0 has priority
    logic last_grant;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (last_grant) begin
                if (req[0])      grant = 2'b01;
                else if (req[1]) grant = 2'b10;
            end else begin
                if (req[1])      grant = 2'b10;
                else if (req[0]) grant = 2'b01;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)         last_grant <= 1'b1;
        else if (grant[0]) last_grant <= 1'b0;
        else if (grant[1]) last_grant <= 1'b1;
    end

endmodule

// File: rtl/adaptimer_cmd_sched.sv
// rtl/adaptimer_cmd_sched.sv - arbitrates timer requests and expands them into spaced command writes
module adaptimer_cmd_sched
    import adaptimer_pkg::*;
#(
    parameter logic [7:0]  RES_RESET    = RES_RESET_DEFAULT,
    parameter logic [7:0]  RES_MIN      = 8'h00,
    parameter logic [7:0]  RES_MAX      = 8'h20,
    parameter logic [31:0] FLUSH_WINDOW = 32'h1000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      req_valid,
    input  logic [1:0][1:0] req_op,
    input  logic [1:0][7:0] req_target,
    output logic [1:0]      req_ready,
    output logic            done,
    output logic            done_id,
    output logic            done_err,
    output logic            slv_reg_wren,
    output logic [2:0]      axi_awaddr,
    output logic [31:0]     S_AXI_WDATA,
    output logic [7:0]      cur_res,
    output logic            locked,
    output logic            flush_active,
    output logic            busy
);

    sched_state_t state, state_nxt;
    req_op_t      op_reg, sel_op;
    logic [7:0]   tgt_reg, sel_tgt;
    logic [2:0]   cmd_reg, dec_cmd;
    logic [31:0]  win_cnt;
    logic         id_reg, err_reg, dec_err, gnt_id, accept;
    logic [1:0]   grant;

    adaptimer_rr_arb u_arb (
        .clock  (clock),
        .reset  (reset),
        .enable (state == ST_IDLE),
        .req    (req_valid),
        .grant  (grant)
    );

    assign accept    = |grant;
    assign gnt_id    = grant[1];
    assign sel_op    = req_op_t'(req_op[gnt_id]);
    assign sel_tgt   = req_target[gnt_id];
    assign req_ready = grant;

    always_comb begin
        state_nxt = state;
        dec_cmd   = CMD_NONE;
        dec_err   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_DONE;
                    case (sel_op)
                        OP_SET_RES: begin
                            if (!res_in_range(sel_tgt, RES_MIN, RES_MAX)) begin
                                dec_err = 1'b1;
                            end else if (sel_tgt > cur_res) begin
                                dec_cmd   = CMD_COARSER;
                                state_nxt = ST_PULSE;
                            end else if (sel_tgt < cur_res) begin
                                dec_cmd   = CMD_FINER;
                                state_nxt = ST_PULSE;
                            end
                        end
                        OP_LOCK: begin
                            dec_cmd   = CMD_LOCK;
                            state_nxt = ST_PULSE;
                        end
                        OP_FLUSH: begin
                            // a window expiring this very cycle does not coalesce
                            if (win_cnt <= 32'd1) begin
                                dec_cmd   = CMD_FLUSH;
                                state_nxt = ST_PULSE;
                            end
                        end
                        default: dec_err = 1'b1;
                    endcase
                end
            end
            ST_PULSE: state_nxt = ST_GAP;
            ST_GAP:   state_nxt = (op_reg == OP_SET_RES && cur_res != tgt_reg) ? ST_PULSE : ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_reg  <= OP_SET_RES;
            tgt_reg <= RES_RESET;
            cmd_reg <= CMD_NONE;
            id_reg  <= 1'b0;
            err_reg <= 1'b0;
            cur_res <= RES_RESET;
            locked  <= 1'b0;
        end else begin
            if (accept) begin
                op_reg  <= sel_op;
                tgt_reg <= sel_tgt;
                cmd_reg <= dec_cmd;
                id_reg  <= gnt_id;
                err_reg <= dec_err;
            end
            if (state == ST_PULSE) begin
                if (cmd_reg == CMD_COARSER) cur_res <= cur_res + 8'd1;
                if (cmd_reg == CMD_FINER)   cur_res <= cur_res - 8'd1;
                if (cmd_reg == CMD_LOCK)    locked  <= 1'b1;
            end
        end
    end

    // +2 covers the timer's own command pipeline latency
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                                         win_cnt <= 32'd0;
        else if (state == ST_PULSE && cmd_reg == CMD_FLUSH) win_cnt <= FLUSH_WINDOW + 32'd2;
        else if (win_cnt != 32'd0)                         win_cnt <= win_cnt - 32'd1;
    end

    assign slv_reg_wren = (state == ST_PULSE);
    assign S_AXI_WDATA  = slv_reg_wren ? {29'd0, cmd_reg} : 32'd0;
    assign axi_awaddr   = 3'h0;
    assign done         = (state == ST_DONE);
    assign done_id      = done & id_reg;
    assign done_err     = done & err_reg;
    assign flush_active = (win_cnt != 32'd0);
    assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_adaptimer_cmd_sched.sv
// tb/tb_adaptimer_cmd_sched.sv - directed self-checking bench for adaptimer_cmd_sched
module tb_adaptimer_cmd_sched;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [1:0]      req_valid = 2'b00;
    logic [1:0][1:0] req_op = '0;
    logic [1:0][7:0] req_target = '0;
    logic [1:0]      req_ready;
    logic            done, done_id, done_err, slv_reg_wren, locked, flush_active, busy;
    logic [2:0]      axi_awaddr;
    logic [31:0]     S_AXI_WDATA;
    logic [7:0]      cur_res;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    adaptimer_cmd_sched dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_op       (req_op),
        .req_target   (req_target),
        .req_ready    (req_ready),
        .done         (done),
        .done_id      (done_id),
        .done_err     (done_err),
        .slv_reg_wren (slv_reg_wren),
        .axi_awaddr   (axi_awaddr),
        .S_AXI_WDATA  (S_AXI_WDATA),
        .cur_res      (cur_res),
        .locked       (locked),
        .flush_active (flush_active),
        .busy         (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Drives a request on one port until accepted (bounded); returns at the negedge of t+1.
    task automatic issue(input int port, input logic [1:0] op, input logic [7:0] tgt);
        int n = 0;
        req_valid[port]  = 1'b1;
        req_op[port]     = op;
        req_target[port] = tgt;
        #1;
        while (req_ready[port] !== 1'b1 && n < 50) begin
            @(negedge clock); #1;
            n++;
        end
        checks++;
        if (req_ready[port] !== 1'b1) begin
            errors++;
            $display("FAIL issue_accept port %0d: req_ready %b required 1", port, req_ready[port]);
        end
        @(negedge clock);
        req_valid[port] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 2'b00;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if ({req_ready, done, done_id, done_err, slv_reg_wren, locked, flush_active, busy} !== 9'b0
            || axi_awaddr !== 3'h0 || S_AXI_WDATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_ctrl: ready/done/id/err/wren/lock/flush/busy %b awaddr %h wdata %h required all zero",
                     {req_ready, done, done_id, done_err, slv_reg_wren, locked, flush_active, busy}, axi_awaddr, S_AXI_WDATA);
        end
        checks++;
        if (cur_res !== 8'h10) begin
            errors++;
            $display("FAIL reset_cur_res: got %h required 10", cur_res);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_set_res_up();
        logic exp_w, exp_d;
        issue(0, 2'd0, 8'h13);
        for (int k = 1; k <= 7; k++) begin
            exp_w = (k % 2 == 1) && (k < 7);
            exp_d = (k == 7);
            checks++;
            if (slv_reg_wren !== exp_w || S_AXI_WDATA !== (exp_w ? 32'd1 : 32'd0)) begin
                errors++;
                $display("FAIL set_res_up_wren t+%0d: wren %b wdata %h required %b %h", k, slv_reg_wren,
                         S_AXI_WDATA, exp_w, exp_w ? 32'd1 : 32'd0);
            end
            checks++;
            if (done !== exp_d) begin
                errors++;
                $display("FAIL set_res_up_done t+%0d: done %b required %b", k, done, exp_d);
            end
            if (k < 7) @(negedge clock);
        end
        checks++;
        if (cur_res !== 8'h13 || done_id !== 1'b0 || done_err !== 1'b0) begin
            errors++;
            $display("FAIL set_res_up_final: cur_res %h id %b err %b required 13 0 0", cur_res, done_id, done_err);
        end
        @(negedge clock);
    endtask

    task automatic test_arbitration();
        req_op[0] = 2'd0; req_target[0] = 8'h0F;
        req_op[1] = 2'd1; req_target[1] = 8'h00;
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL arb_first_grant: req_ready %b required 01", req_ready);
        end
        @(negedge clock);
        req_valid[0] = 1'b0;
        #1;
        checks++;
        if (slv_reg_wren !== 1'b1 || S_AXI_WDATA !== 32'd2 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL arb_finer_pulse: wren %b wdata %h ready %b required 1 2 00", slv_reg_wren, S_AXI_WDATA, req_ready);
        end
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (done !== 1'b1 || done_id !== 1'b0 || cur_res !== 8'h0F) begin
            errors++;
            $display("FAIL arb_done0: done %b id %b cur_res %h required 1 0 0f", done, done_id, cur_res);
        end
        @(negedge clock); #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL arb_second_grant: req_ready %b required 10", req_ready);
        end
        @(negedge clock);
        req_valid[1] = 1'b0;
        checks++;
        if (slv_reg_wren !== 1'b1 || S_AXI_WDATA !== 32'd3) begin
            errors++;
            $display("FAIL arb_lock_pulse: wren %b wdata %h required 1 3", slv_reg_wren, S_AXI_WDATA);
        end
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (done !== 1'b1 || done_id !== 1'b1 || done_err !== 1'b0 || locked !== 1'b1 || cur_res !== 8'h0F) begin
            errors++;
            $display("FAIL arb_done1: done %b id %b err %b locked %b cur_res %h required 1 1 0 1 0f",
                     done, done_id, done_err, locked, cur_res);
        end
        @(negedge clock);
    endtask

    task automatic test_range_err();
        issue(0, 2'd0, 8'h21);
        checks++;
        if (done !== 1'b1 || done_err !== 1'b1 || slv_reg_wren !== 1'b0 || cur_res !== 8'h0F) begin
            errors++;
            $display("FAIL range_err: done %b err %b wren %b cur_res %h required 1 1 0 0f",
                     done, done_err, slv_reg_wren, cur_res);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL range_err_single: done %b busy %b required 0 0", done, busy);
        end
        issue(0, 2'd0, 8'h0F);
        checks++;
        if (done !== 1'b1 || done_err !== 1'b0 || slv_reg_wren !== 1'b0) begin
            errors++;
            $display("FAIL set_res_noop: done %b err %b wren %b required 1 0 0", done, done_err, slv_reg_wren);
        end
        @(negedge clock);
    endtask

    task automatic test_reserved();
        issue(1, 2'd3, 8'h00);
        checks++;
        if (done !== 1'b1 || done_err !== 1'b1 || done_id !== 1'b1 || slv_reg_wren !== 1'b0) begin
            errors++;
            $display("FAIL reserved_op: done %b err %b id %b wren %b required 1 1 1 0",
                     done, done_err, done_id, slv_reg_wren);
        end
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        int seen_done = 0;
        issue(0, 2'd0, 8'h14);
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (slv_reg_wren !== 1'b1 || cur_res !== 8'h11) begin
            errors++;
            $display("FAIL reset_mid_step2: wren %b cur_res %h required 1 11", slv_reg_wren, cur_res);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (slv_reg_wren !== 1'b0 || cur_res !== 8'h10 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: wren %b cur_res %h busy %b done %b required 0 10 0 0",
                     slv_reg_wren, cur_res, busy, done);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (done !== 1'b0 || slv_reg_wren !== 1'b0) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL reset_mid_dropped: %0d cycles with done or wren, required 0", seen_done);
        end
    endtask

    task automatic test_flush();
        int p;
        issue(0, 2'd2, 8'h00);
        p = cyc;
        checks++;
        if (slv_reg_wren !== 1'b1 || S_AXI_WDATA !== 32'd4) begin
            errors++;
            $display("FAIL flush_pulse: wren %b wdata %h required 1 4", slv_reg_wren, S_AXI_WDATA);
        end
        @(negedge clock);
        checks++;
        if (flush_active !== 1'b1) begin
            errors++;
            $display("FAIL flush_active_set: got %b required 1", flush_active);
        end
        while (cyc < p + 10) @(negedge clock);
        issue(0, 2'd2, 8'h00);
        checks++;
        if (done !== 1'b1 || done_err !== 1'b0 || slv_reg_wren !== 1'b0) begin
            errors++;
            $display("FAIL flush_coalesce: done %b err %b wren %b required 1 0 0", done, done_err, slv_reg_wren);
        end
        while (cyc < p + 4098) @(negedge clock);
        checks++;
        if (flush_active !== 1'b1) begin
            errors++;
            $display("FAIL flush_window_last: flush_active %b at pulse+4098 required 1", flush_active);
        end
        req_op[1] = 2'd2;
        req_valid[1] = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL flush_edge_accept: req_ready %b required 10", req_ready);
        end
        @(negedge clock);
        req_valid[1] = 1'b0;
        checks++;
        if (flush_active !== 1'b0 || slv_reg_wren !== 1'b1 || S_AXI_WDATA !== 32'd4) begin
            errors++;
            $display("FAIL flush_edge_pulse: flush_active %b wren %b wdata %h required 0 1 4",
                     flush_active, slv_reg_wren, S_AXI_WDATA);
        end
        @(negedge clock);
        checks++;
        if (flush_active !== 1'b1) begin
            errors++;
            $display("FAIL flush_reload: flush_active %b required 1", flush_active);
        end
        @(negedge clock);
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_set_res_up();
        test_reset();
        test_arbitration();
        test_range_err();
        test_reserved();
        test_reset();
        test_reset_mid();
        test_reset();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adaptimer_cmd_sched.md
# adaptimer_cmd_sched

Command scheduler for the adaptive-resolution timer. It accepts high-level requests from two requesters: port 0 is software and port 1 is the flush/side-channel monitor. It arbitrates between them round-robin and expands each granted request into the single-cycle command writes the timer's control register expects (1 = coarser, 2 = finer, 3 = lock safe resolution, 4 = flush). It also keeps shadow state of the timer's current resolution, lock status and flush window, so requesters never issue raw opcodes.

## Interface
Parameters:
- RES_RESET, 8'h10, timer resolution after reset; must match the timer.
- RES_MIN, 8'h00, lowest legal resolution (finest).
- RES_MAX, 8'h20, highest legal resolution (coarsest).
- FLUSH_WINDOW, 32'h1000, safe-window length the timer holds after a flush.

Ports:
- clock, in, 1, sole clock.
- reset, in, 1, asynchronous, active-high.
- req_valid, in, 2, per-port request valid.
- req_op, in, 2x2, per-port opcode: 0 = SET_RES, 1 = LOCK, 2 = FLUSH, 3 = reserved.
- req_target, in, 2x8, per-port target resolution; SET_RES only.
- req_ready, out, 2, per-port accept; asserted high only in the accepting cycle.
- done, out, 1, one-cycle completion pulse.
- done_id, out, 1, port that owned the completed request; valid with done.
- done_err, out, 1, request rejected, no command issued; valid with done.
- slv_reg_wren, out, 1, timer command write strobe.
- axi_awaddr, out, 3, always 3'h0.
- S_AXI_WDATA, out, 32, command opcode; 32'h0 when wren is low.
- cur_res, out, 8, shadow resolution.
- locked, out, 1, at least one LOCK issued since reset.
- flush_active, out, 1, shadow flush window running.
- busy, out, 1, FSM not in IDLE.

## Operation
- FSM states:
  - IDLE: arbitrate, accept, decode.
  - PULSE: wren = 1 for one cycle.
  - GAP: wren = 0 for one cycle.
  - DONE: done pulse for one cycle.
- Arbitration:
  - Round-robin; after reset port 0 has priority.
  - After any grant, the other port has priority.
  - Only one req_ready is high per cycle, and only in IDLE.
- SET_RES:
  - Target outside [RES_MIN, RES_MAX]: go to DONE with done_err = 1.
  - Target equal to cur_res: go to DONE, no pulses.
  - Otherwise alternate PULSE/GAP, one step per pair. Opcode is 1 if target > cur_res, 2 if target < cur_res.
  - cur_res moves by ±1 at the end of each PULSE cycle.
  - After the final GAP, go to DONE.
- LOCK:
  - One PULSE with opcode 3, then GAP, then DONE.
  - locked sets at the end of the PULSE and stays set until reset. Re-LOCK is allowed.
- FLUSH:
  - If flush_active = 0: one PULSE with opcode 4, then GAP, then DONE.
  - The window counter loads FLUSH_WINDOW+2 at the end of the PULSE; the +2 covers the timer's command pipeline.
  - If flush_active = 1: the request is coalesced. Go straight to DONE with no pulse, no reload and done_err = 0.
- Reserved opcode: DONE with done_err = 1.
- Window counter:
  - Decrements every cycle while non-zero, in any FSM state.
  - flush_active = (counter != 0).
- Pulses never occur on consecutive cycles, so every timer command is separated by at least one idle cycle.

## Timing
- Reset values:
  - Outputs: req_ready = 0, done = 0, done_id = 0, done_err = 0, slv_reg_wren = 0, axi_awaddr = 0, S_AXI_WDATA = 0, cur_res = RES_RESET, locked = 0, flush_active = 0, busy = 0.
  - Internal: FSM in IDLE, window counter 0.
- Accept cycle t (valid & ready):
  - First PULSE at t+1.
  - A request with N pulses raises done at t+2N+1.
  - A zero-pulse request (no-op, rejected, reserved, coalesced) raises done at t+1.
- After DONE, the FSM is in IDLE and can accept again the next cycle, so the minimum spacing between accepts is 2 cycles for zero-pulse requests.
- req_valid may drop without being accepted; a request is only captured on the accept cycle.
- If the window counter reaches 0 in the same cycle a FLUSH is decoded, the FLUSH is not coalesced (it issues a pulse).
- Reset asserted mid-request: all outputs return to reset values immediately; the in-flight request is dropped with no done.

## Structure
- Shared package adaptimer_pkg:
  - Timer opcodes CMD_COARSER = 1, CMD_FINER = 2, CMD_LOCK = 3, CMD_FLUSH = 4.
  - Request op encodings.
  - FSM state typedef.
  - RES_RESET default.
  - The timer will import the same opcodes.
- One natural sub-module: adaptimer_rr_arb, a 2-port round-robin arbiter with a last-grant register.

## Test plan
- Reset then SET_RES target 8'h13 on port 0: wren pulses with WDATA 1 at t+1, t+3, t+5; cur_res ends at 8'h13; done with done_id 0 at t+7.
- Both ports valid in the same cycle after reset (port 0 SET_RES 8'h0F, port 1 LOCK): port 0 granted first (one finer step); port 1 granted on the next IDLE; locked = 1; cur_res = 8'h0F.
- SET_RES 8'h21 with RES_MAX 8'h20: done_err = 1 at t+1, no wren, cur_res unchanged.
- FLUSH issued, then a second FLUSH 10 cycles later: the second completes at t+1 with no pulse; flush_active drops exactly 4098 cycles after the first pulse.
- Reset asserted during the second step of a 4-step SET_RES: wren low immediately, cur_res = 8'h10, busy = 0, no done.
- Reserved op 3 on port 1: done_err = 1, done_id = 1, no wren.
